me_search_controller: RTL



---
 rtl/me_search_controller.sv | 131 +++++++++++++
 1 files changed

// File: rtl/me_search_controller.sv
// Full-search block-matching sequencer: one N x N reference block against every
// candidate of a (2N-1) x (2N-1) window, one pixel per clock, with hold/abort/drain.
module me_search_controller #(
   parameter  int N   = 16,
   localparam int LN  = $clog2(N),
   localparam int CW  = 3*LN + 1,
   localparam int SAW = 2*LN + 2
) (
   input  logic           clock,
   input  logic           reset_n,
   input  logic           start,
   input  logic           hold,
   input  logic           abort,
   output logic           busy,
   output logic           done,
   output logic           comp_start,
   output logic [N-1:0]   new_dist,
   output logic [N-1:0]   pe_ready,
   output logic [N-1:0]   s1s2_mux,
   output logic [LN:0]    vector_x,
   output logic [LN:0]    vector_y,
   output logic [2*LN-1:0] address_r,
   output logic [SAW-1:0] address_s1,
   output logic [SAW-1:0] address_s2
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam int            T    = N*(N*N + 1);
   localparam logic [CW-1:0] LAST = CW'(T - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic          done_q, done_d;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values from before this edge, regardless of block ordering.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         count_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         done_q  <= done_d;
      end
   end

   // NOTE: every variable gets a default before the case so no path leaves one
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               state_d = RUN;
               count_d = '0;
            end
         end
         RUN: begin
            // abort wins over hold and over the terminal count
            if (abort) begin
               state_d = IDLE;
               count_d = '0;
            end else if (!hold) begin
               if (count_q == LAST) begin
                  state_d = IDLE;
                  count_d = '0;
                  done_d  = 1'b1;
               end else begin
                  count_d = count_q + 1'b1;
               end
            end
         end
      endcase
   end

   function automatic logic [SAW-1:0] search_addr(input logic [LN:0]   v,
                                                  input logic [LN-1:0] row,
                                                  input logic [LN-1:0] col);
      return (SAW'(v) + SAW'(row)) * SAW'(2*N - 1) + SAW'(col);
   endfunction

   logic [CW-1:0]  count_t;
   logic [LN-1:0]  col, row, col_t, row_t;
   logic [LN:0]    v, v_t;
   logic           running;

   assign running = (state_q == RUN);
   assign col     = count_q[LN-1:0];
   assign row     = count_q[2*LN-1:LN];
   assign v       = count_q[CW-1:2*LN];
   // Second search port trails the first by N pixels (the next PE column).
   assign count_t = count_q - CW'(N);
   assign col_t   = count_t[LN-1:0];
   assign row_t   = count_t[2*LN-1:LN];
   assign v_t     = count_t[CW-1:2*LN];

   always_comb begin
      comp_start = 1'b0;
      new_dist   = '0;
      pe_ready   = '0;
      s1s2_mux   = '0;
      vector_x   = '0;
      vector_y   = '0;
      address_r  = '0;
      address_s1 = '0;
      address_s2 = '0;
      if (running) begin
         address_r  = count_q[2*LN-1:0];
         address_s1 = search_addr(v, row, col);
         if (count_q >= CW'(N))
            address_s2 = search_addr(v_t, row_t, col_t) + SAW'(N);
         comp_start = (count_q >= CW'(N*N));
         for (int i = 0; i < N; i++) begin
            new_dist[i] = (count_q[2*LN-1:0] == (2*LN)'(i));
            s1s2_mux[i] = (col >= LN'(i));
         end
         pe_ready   = comp_start ? new_dist : '0;
         vector_x   = {1'b0, col} - (LN+1)'(N/2);
         vector_y   = v - (LN+1)'(N/2 + 1);
      end
   end

   assign busy = running;
   assign done = done_q;

endmodule
